// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: initiator side of a 3-bit-opcode / WIDTH-bit ALU operand port.
// Commands arrive over a valid/ready port and are registered toward the ALU
// (Op_code/A/B). The combinational result Y is sampled one cycle later, kept
// as the chaining accumulator, and buffered in a DEPTH-entry result FIFO that
// drains over a valid/ready response port.
// Optional build macro: ALU_CMD_DRIVER_ZERO_FLAG_EN adds a per-entry zero flag
// (output rsp_zero) that travels with rsp_data.
module alu_cmd_driver #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic [2:0]       Op_code,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_CMD_DRIVER_ZERO_FLAG_EN
    output logic             rsp_zero,
`endif
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_e;

    state_e             state_q;
    logic               run_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_q;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];

    logic               accept;
    logic               push;
    logic               pop;

    // Handshake qualifiers; run_q holds cmd_ready low until the first edge after reset release.
    assign cmd_ready = run_q && (state_q == S_IDLE) && (count_q < DEPTH_C);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = (state_q == S_EXEC);
    assign rsp_valid = (count_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = (state_q == S_EXEC) || rsp_valid;

    // Head entry is masked to zero while empty so stale storage never shows.
    assign rsp_data  = rsp_valid ? mem_q[rd_ptr_q] : '0;

    assign Op_code   = op_q;
    assign A         = a_q;
    assign B         = b_q;

    // Command FSM: registers operands toward the ALU, then captures Y into acc.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            run_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= cmd_op;
                        b_q     <= cmd_b;
                        a_q     <= cmd_chain ? acc_q : cmd_a;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc_q   <= Y;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // FIFO pointer/count next-state; push and pop on the same edge leave count unchanged.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer/count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Result storage; captured Y is written at the tail on the EXEC edge.
    // NOTE: storage has no reset; occupancy is tracked by count_q and outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= Y;
        end
    end

`ifdef ALU_CMD_DRIVER_ZERO_FLAG_EN
    logic zmem_q [DEPTH];

    // Per-entry zero flag, written alongside the result.
    always_ff @(posedge clk) begin
        if (push) begin
            zmem_q[wr_ptr_q] <= (Y == '0);
        end
    end

    assign rsp_zero = rsp_valid && zmem_q[rd_ptr_q];
`endif

endmodule
